// File: rtl/ntt_butterfly_pe.sv
// ntt_butterfly_pe: radix-2 CT/GS modular butterfly with a scheduled, runtime-loadable twiddle table
module ntt_butterfly_pe #(
  parameter int W = 28,
  parameter longint unsigned Q = 64'd268369921,
  parameter int NTW = 8,
  parameter int START = 6,
  parameter int REPEAT = 1,
  parameter int MUL_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic                    mode_in,
  input  logic [W-1:0]            x_in,
  input  logic [W-1:0]            y_in,
  input  logic                    tw_wr_en,
  input  logic [$clog2(NTW)-1:0]  tw_wr_addr,
  input  logic [W-1:0]            tw_wr_data,
  output logic                    out_valid,
  output logic [W-1:0]            x_out,
  output logic [W-1:0]            y_out,
  output logic [$clog2(NTW)-1:0]  tw_idx
);
  localparam int AW = $clog2(NTW);
  localparam int PW = $clog2(START + 2);
  localparam int RW = $clog2(REPEAT + 1);
  localparam logic [W-1:0] QM = W'(Q);

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= {1'b0, QM}) ? W'(s - {1'b0, QM}) : W'(s);
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a >= b) ? a - b : a - b + QM;
  endfunction

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(p % {{W{1'b0}}, QM});
  endfunction

  logic [PW-1:0]              pre_q, pre_d, pre_c;
  logic [RW-1:0]              rep_q, rep_d, rep_c;
  logic [AW-1:0]              idx_q, idx_d, idx_c;
  logic [NTW-1:0][W-1:0]      tbl_q, tbl_d;
  logic                       s0_v_q, s0_v_d, s0_m_q, s0_m_d;
  logic [W-1:0]               s0_a_q, s0_a_d, s0_b_q, s0_b_d, s0_w_q, s0_w_d;
  logic [MUL_LAT-1:0]         mv_q, mv_d, mm_q, mm_d;
  logic [MUL_LAT-1:0][W-1:0]  mx_q, mx_d, mp_q, mp_d, mx_sh, mp_sh;
  logic                       ov_q, ov_d, lm;
  logic [W-1:0]               xo_q, xo_d, yo_q, yo_d, lx, lp;

  // clr zeroes the schedule for the sample accepted in the same cycle as well
  always_comb begin
    pre_c = clr ? '0 : pre_q;
    rep_c = clr ? '0 : rep_q;
    idx_c = clr ? '0 : idx_q;
    pre_d = pre_c;
    rep_d = rep_c;
    idx_d = idx_c;
    if (in_valid) begin
      if (pre_c < PW'(START)) pre_d = pre_c + 1'b1;
      else if (rep_c == RW'(REPEAT - 1)) begin
        rep_d = '0;
        idx_d = idx_c + 1'b1;
      end else rep_d = rep_c + 1'b1;
    end
    tbl_d = tbl_q;
    if (tw_wr_en) tbl_d[tw_wr_addr] = tw_wr_data;
  end

  // GS does its add/sub up front; CT passes x/y straight to the multiplier
  always_comb begin
    s0_v_d = in_valid;
    s0_m_d = in_valid ? mode_in : s0_m_q;
    s0_a_d = in_valid ? (mode_in ? mod_add(x_in, y_in) : x_in) : s0_a_q;
    s0_b_d = in_valid ? (mode_in ? mod_sub(x_in, y_in) : y_in) : s0_b_q;
    s0_w_d = in_valid ? tbl_q[idx_c] : s0_w_q;
  end

  always_comb begin
    mv_d  = MUL_LAT'({mv_q, s0_v_q});
    mm_d  = MUL_LAT'({mm_q, s0_m_q});
    mx_sh = (MUL_LAT*W)'({mx_q, s0_a_q});
    mp_sh = (MUL_LAT*W)'({mp_q, mod_mul(s0_b_q, s0_w_q)});
    for (int i = 0; i < MUL_LAT; i++) begin
      mx_d[i] = mv_d[i] ? mx_sh[i] : mx_q[i];
      mp_d[i] = mv_d[i] ? mp_sh[i] : mp_q[i];
    end
  end

  always_comb begin
    lm   = mm_q[MUL_LAT-1];
    lx   = mx_q[MUL_LAT-1];
    lp   = mp_q[MUL_LAT-1];
    ov_d = mv_q[MUL_LAT-1];
    xo_d = ov_d ? (lm ? lx : mod_add(lx, lp)) : xo_q;
    yo_d = ov_d ? (lm ? lp : mod_sub(lx, lp)) : yo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      rep_q  <= '0;
      idx_q  <= '0;
      for (int i = 0; i < NTW; i++) tbl_q[i] <= W'(1);
      s0_v_q <= 1'b0;
      s0_m_q <= 1'b0;
      s0_a_q <= '0;
      s0_b_q <= '0;
      s0_w_q <= '0;
      mv_q   <= '0;
      mm_q   <= '0;
      mx_q   <= '0;
      mp_q   <= '0;
      ov_q   <= 1'b0;
      xo_q   <= '0;
      yo_q   <= '0;
    end else begin
      pre_q  <= pre_d;
      rep_q  <= rep_d;
      idx_q  <= idx_d;
      tbl_q  <= tbl_d;
      s0_v_q <= s0_v_d;
      s0_m_q <= s0_m_d;
      s0_a_q <= s0_a_d;
      s0_b_q <= s0_b_d;
      s0_w_q <= s0_w_d;
      mv_q   <= mv_d;
      mm_q   <= mm_d;
      mx_q   <= mx_d;
      mp_q   <= mp_d;
      ov_q   <= ov_d;
      xo_q   <= xo_d;
      yo_q   <= yo_d;
    end
  end

  assign out_valid = ov_q;
  assign x_out     = xo_q;
  assign y_out     = yo_q;
  assign tw_idx    = idx_q;
endmodule

// File: tb/tb_ntt_butterfly_pe.sv
// tb_ntt_butterfly_pe: directed-vector bench for the CT/GS butterfly, twiddle schedule, clr and reset
module tb_ntt_butterfly_pe;
  localparam int W = 28;
  localparam logic [W-1:0] Q = 28'd268369921;
  localparam int NTW = 4;
  localparam int AW = 2;
  localparam int LAT = 6;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, in_valid = 1'b0, mode_in = 1'b0, tw_wr_en = 1'b0;
  logic [W-1:0] x_in = '0, y_in = '0, tw_wr_data = '0;
  logic [AW-1:0] tw_wr_addr = '0;
  logic out_valid;
  logic [W-1:0] x_out, y_out;
  logic [AW-1:0] tw_idx;
  int errors = 0, checks = 0;
  logic sm [16];
  logic ov [16];
  logic [W-1:0] sx [16], sy [16], ox [16], oy [16];
  logic early0 = 1'b0, wr0 = 1'b0, clr0 = 1'b0;
  logic [W-1:0] wr0_data = '0;

  always #5 clk = ~clk;

  ntt_butterfly_pe #(.W(W), .Q(64'd268369921), .NTW(NTW), .START(2), .REPEAT(2), .MUL_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .mode_in(mode_in),
    .x_in(x_in), .y_in(y_in), .tw_wr_en(tw_wr_en), .tw_wr_addr(tw_wr_addr), .tw_wr_data(tw_wr_data),
    .out_valid(out_valid), .x_out(x_out), .y_out(y_out), .tw_idx(tw_idx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_tw(input logic [AW-1:0] a, input logic [W-1:0] d);
    tw_wr_en = 1'b1; tw_wr_addr = a; tw_wr_data = d;
    tick();
    tw_wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // drives n back-to-back samples and captures the output of sample i exactly LAT cycles after its accept
  task automatic stream(input int n);
    for (int j = 0; j < n + LAT; j++) begin
      if (j == LAT - 1) early0 = out_valid;
      if (j >= LAT) begin
        ov[j-LAT] = out_valid; ox[j-LAT] = x_out; oy[j-LAT] = y_out;
      end
      in_valid = (j < n);
      clr = (j == 0) && clr0;
      tw_wr_en = (j == 0) && wr0; tw_wr_addr = '0; tw_wr_data = wr0_data;
      if (j < n) begin
        mode_in = sm[j]; x_in = sx[j]; y_in = sy[j];
      end
      tick();
    end
    in_valid = 1'b0; clr = 1'b0; tw_wr_en = 1'b0; clr0 = 1'b0; wr0 = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (x_out !== '0) begin errors++; $display("FAIL reset_x: got %0d want 0", x_out); end
    checks++; if (y_out !== '0) begin errors++; $display("FAIL reset_y: got %0d want 0", y_out); end
    checks++; if (tw_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d want 0", tw_idx); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ct();
    sm[0] = 1'b0; sx[0] = 28'd5; sy[0] = 28'd3;
    stream(1);
    checks++; if (early0 !== 1'b0) begin errors++; $display("FAIL ct_early: got %b want 0", early0); end
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL ct_valid: got %b want 1", ov[0]); end
    checks++; if (ox[0] !== 28'd8) begin errors++; $display("FAIL ct_x: got %0d want 8", ox[0]); end
    checks++; if (oy[0] !== 28'd2) begin errors++; $display("FAIL ct_y: got %0d want 2", oy[0]); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ct_valid_drop: got %b want 0", out_valid); end
    checks++; if (x_out !== 28'd8) begin errors++; $display("FAIL ct_hold: got %0d want 8", x_out); end
  endtask

  task automatic test_ct_wrap();
    logic [W-1:0] ex [2], ey [2];
    ex = '{28'd1, 28'd1};
    ey = '{28'd268369918, 28'd268369920};
    sm[0] = 1'b0; sx[0] = Q - 28'd1; sy[0] = 28'd2;
    sm[1] = 1'b0; sx[1] = 28'd0;     sy[1] = 28'd1;
    stream(2);
    for (int i = 0; i < 2; i++) begin
      checks++; if (ox[i] !== ex[i]) begin errors++; $display("FAIL wrap_x[%0d]: got %0d want %0d", i, ox[i], ex[i]); end
      checks++; if (oy[i] !== ey[i]) begin errors++; $display("FAIL wrap_y[%0d]: got %0d want %0d", i, oy[i], ey[i]); end
    end
  endtask

  task automatic test_gs();
    for (int a = 0; a < NTW; a++) write_tw(AW'(a), 28'd2);
    sm[0] = 1'b1; sx[0] = 28'd10; sy[0] = 28'd4;
    stream(1);
    checks++; if (ov[0] !== 1'b1) begin errors++; $display("FAIL gs_valid: got %b want 1", ov[0]); end
    checks++; if (ox[0] !== 28'd14) begin errors++; $display("FAIL gs_x: got %0d want 14", ox[0]); end
    checks++; if (oy[0] !== 28'd12) begin errors++; $display("FAIL gs_y: got %0d want 12", oy[0]); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ex [4], ey [4];
    ex = '{28'd18, 28'd8, 28'd268369920, 28'd268369919};
    ey = '{28'd2, 28'd268369917, 28'd3, 28'd0};
    sm[0] = 1'b0; sx[0] = 28'd10;      sy[0] = 28'd4;
    sm[1] = 1'b1; sx[1] = 28'd3;       sy[1] = 28'd5;
    sm[2] = 1'b0; sx[2] = 28'd1;       sy[2] = Q - 28'd1;
    sm[3] = 1'b1; sx[3] = Q - 28'd1;   sy[3] = Q - 28'd1;
    stream(4);
    for (int i = 0; i < 4; i++) begin
      checks++; if (ov[i] !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, ov[i]); end
      checks++; if (ox[i] !== ex[i]) begin errors++; $display("FAIL b2b_x[%0d]: got %0d want %0d", i, ox[i], ex[i]); end
      checks++; if (oy[i] !== ey[i]) begin errors++; $display("FAIL b2b_y[%0d]: got %0d want %0d", i, oy[i], ey[i]); end
    end
  endtask

  task automatic test_schedule();
    logic [W-1:0] ex [12];
    ex = '{28'd1, 28'd1, 28'd1, 28'd1, 28'd2, 28'd2, 28'd3, 28'd3, 28'd4, 28'd4, 28'd1, 28'd1};
    for (int a = 0; a < NTW; a++) write_tw(AW'(a), W'(a + 1));
    pulse_clr();
    for (int i = 0; i < 12; i++) begin
      sm[i] = 1'b0; sx[i] = 28'd0; sy[i] = 28'd1;
    end
    stream(12);
    for (int i = 0; i < 12; i++) begin
      checks++; if (ox[i] !== ex[i]) begin errors++; $display("FAIL sched_x[%0d]: got %0d want %0d", i, ox[i], ex[i]); end
      checks++; if (oy[i] !== Q - ex[i]) begin errors++; $display("FAIL sched_y[%0d]: got %0d want %0d", i, oy[i], Q - ex[i]); end
    end
    checks++; if (tw_idx !== 2'd1) begin errors++; $display("FAIL sched_idx: got %0d want 1", tw_idx); end
  endtask

  task automatic test_same_cycle_write();
    pulse_clr();
    for (int i = 0; i < 2; i++) begin
      sm[i] = 1'b0; sx[i] = 28'd0; sy[i] = 28'd1;
    end
    wr0 = 1'b1; wr0_data = 28'd7;
    stream(2);
    checks++; if (ox[0] !== 28'd1) begin errors++; $display("FAIL wr_old: got %0d want 1", ox[0]); end
    checks++; if (ox[1] !== 28'd7) begin errors++; $display("FAIL wr_new_x: got %0d want 7", ox[1]); end
    checks++; if (oy[1] !== 28'd268369914) begin errors++; $display("FAIL wr_new_y: got %0d want 268369914", oy[1]); end
  endtask

  task automatic test_reset_midstream();
    logic stale;
    stale = 1'b0;
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1; mode_in = 1'b0; x_in = 28'd0; y_in = 28'd1;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
    checks++; if (x_out !== '0) begin errors++; $display("FAIL mid_async_x: got %0d want 0", x_out); end
    checks++; if (tw_idx !== '0) begin errors++; $display("FAIL mid_async_idx: got %0d want 0", tw_idx); end
    tick();
    #3 rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL mid_stale: got %b want 0", stale); end
    sm[0] = 1'b0; sx[0] = 28'd0; sy[0] = 28'd1;
    stream(1);
    checks++; if (ox[0] !== 28'd1) begin errors++; $display("FAIL mid_table_reset: got %0d want 1", ox[0]); end
  endtask

  task automatic test_clr();
    logic [W-1:0] ex [5];
    ex = '{28'd5, 28'd5, 28'd5, 28'd5, 28'd9};
    write_tw(2'd0, 28'd5);
    write_tw(2'd1, 28'd9);
    for (int i = 0; i < 5; i++) begin
      sm[i] = 1'b0; sx[i] = 28'd0; sy[i] = 28'd1;
    end
    stream(3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ox[i] !== 28'd5) begin errors++; $display("FAIL clr_pre[%0d]: got %0d want 5", i, ox[i]); end
    end
    clr0 = 1'b1;
    stream(5);
    for (int i = 0; i < 5; i++) begin
      checks++; if (ox[i] !== ex[i]) begin errors++; $display("FAIL clr_x[%0d]: got %0d want %0d", i, ox[i], ex[i]); end
    end
    checks++; if (tw_idx !== 2'd1) begin errors++; $display("FAIL clr_idx: got %0d want 1", tw_idx); end
  endtask

  initial begin
    test_reset();
    test_ct();
    test_ct_wrap();
    test_gs();
    test_back_to_back();
    test_schedule();
    test_same_cycle_write();
    test_reset_midstream();
    test_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
